// File: rtl/blink_sequencer_if.sv
// Configuration channel into blink_sequencer: mode and timing fields on a valid/ready handshake.
// The source holds every field stable while cfg_valid is high and cfg_ready is low.
interface blink_sequencer_if #(
   parameter int CNT_W   = 24,
   parameter int BURST_W = 4
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_mode;
   logic [CNT_W-1:0]   cfg_half_period;
   logic [BURST_W-1:0] cfg_burst_count;
   logic [BURST_W-1:0] cfg_gap_halves;

   modport master (
      output cfg_valid, cfg_mode, cfg_half_period, cfg_burst_count, cfg_gap_halves,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_half_period, cfg_burst_count, cfg_gap_halves,
      output cfg_ready
   );
endinterface

// File: rtl/blink_sequencer.sv
// Prescaled LED pacing: OFF / ON / BLINK / BURST patterns, led_req and tick registered one cycle after the deciding edge.
// Config is refused (cfg_ready=0) only while a burst's pulse phase runs; an accept overrides any same-cycle boundary.
module blink_sequencer #(
   parameter int CNT_W               = 24,
   parameter int BURST_W             = 4,
   parameter int DEFAULT_HALF_PERIOD = 12500000
) (
   input  logic             clk,
   input  logic             rst,
   blink_sequencer_if.slave cfg,
   output logic             led_req,
   output logic             tick,
   output logic             busy
);
   typedef enum logic [2:0] {
      S_OFF,
      S_ON,
      S_BLINK,
      S_B_PULSE,
      S_B_GAP
   } state_t;

   localparam logic [1:0]         MODE_OFF   = 2'd0;
   localparam logic [1:0]         MODE_ON    = 2'd1;
   localparam logic [1:0]         MODE_BLINK = 2'd2;
   localparam logic [1:0]         MODE_BURST = 2'd3;
   localparam logic [CNT_W-1:0]   DEF_HP     = CNT_W'(DEFAULT_HALF_PERIOD);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [BURST_W-1:0] B_ONE      = BURST_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hp_q, hp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [BURST_W-1:0] gap_q, gap_d;
   logic [BURST_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [BURST_W-1:0] gap_cnt_q, gap_cnt_d;
   logic               led_q, led_d;
   logic               tick_q, tick_d;

   logic accept;
   logic counting;
   logic boundary;

   assign busy          = (state_q == S_B_PULSE);
   assign cfg.cfg_ready = ~busy;
   assign accept        = cfg.cfg_valid & ~busy;
   assign counting      = (state_q == S_BLINK) || (state_q == S_B_PULSE) || (state_q == S_B_GAP);
   assign boundary      = counting && (cnt_q == hp_q - CNT_ONE);
   assign led_req       = led_q;
   assign tick          = tick_q;

   always_comb begin
      state_d     = state_q;
      hp_d        = hp_q;
      burst_d     = burst_q;
      gap_d       = gap_q;
      pulse_cnt_d = pulse_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      led_d       = led_q;
      tick_d      = 1'b0;
      cnt_d       = '0;
      if (counting && !boundary) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (accept) begin
         // Zero clamps are applied once here so every later compare uses legal values.
         hp_d        = (cfg.cfg_half_period == '0) ? CNT_ONE : cfg.cfg_half_period;
         burst_d     = (cfg.cfg_burst_count == '0) ? B_ONE : cfg.cfg_burst_count;
         gap_d       = cfg.cfg_gap_halves;
         cnt_d       = '0;
         pulse_cnt_d = '0;
         gap_cnt_d   = '0;
         case (cfg.cfg_mode)
            MODE_ON: begin
               state_d = S_ON;
               led_d   = 1'b1;
            end
            MODE_BLINK: begin
               state_d = S_BLINK;
               led_d   = 1'b1;
            end
            MODE_BURST: begin
               state_d = S_B_PULSE;
               led_d   = 1'b1;
            end
            default: begin
               state_d = S_OFF;
               led_d   = 1'b0;
            end
         endcase
      end else if (boundary) begin
         tick_d = 1'b1;
         case (state_q)
            S_BLINK: begin
               led_d = ~led_q;
            end
            S_B_PULSE: begin
               led_d = ~led_q;
               // A falling edge closes one pulse; the last one hands the low half to the gap.
               if (led_q) begin
                  if (pulse_cnt_q + B_ONE == burst_q) begin
                     pulse_cnt_d = '0;
                     if (gap_q != '0) begin
                        state_d   = S_B_GAP;
                        gap_cnt_d = '0;
                     end
                  end else begin
                     pulse_cnt_d = pulse_cnt_q + B_ONE;
                  end
               end
            end
            S_B_GAP: begin
               led_d = 1'b0;
               if (gap_cnt_q == gap_q) begin
                  state_d     = S_B_PULSE;
                  led_d       = 1'b1;
                  gap_cnt_d   = '0;
                  pulse_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + B_ONE;
               end
            end
            default: begin
               led_d = led_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_OFF;
         hp_q        <= DEF_HP;
         cnt_q       <= '0;
         burst_q     <= B_ONE;
         gap_q       <= '0;
         pulse_cnt_q <= '0;
         gap_cnt_q   <= '0;
         led_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hp_q        <= hp_d;
         cnt_q       <= cnt_d;
         burst_q     <= burst_d;
         gap_q       <= gap_d;
         pulse_cnt_q <= pulse_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         led_q       <= led_d;
         tick_q      <= tick_d;
      end
   end
endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: vector table, hand-written corner sequences and a random run,
// all judged against a pattern model built from cycle counts since the last accept.
module tb_blink_sequencer;
   localparam int CNT_W   = 8;
   localparam int BURST_W = 4;
   localparam int DHP     = 4;

   logic clk = 1'b0;
   logic rst;
   logic led_req, tick, busy;
   int   checks = 0;
   int   errors = 0;

   blink_sequencer_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

   blink_sequencer #(
      .CNT_W(CNT_W),
      .BURST_W(BURST_W),
      .DEFAULT_HALF_PERIOD(DHP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg(cfg_if),
      .led_req(led_req),
      .tick(tick),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: active mode, clamped fields, and t = cycles elapsed since the accept (t=0 is the first cycle after it).
   int m_mode = 0;
   int m_hp   = 1;
   int m_b    = 1;
   int m_g    = 0;
   int m_t    = 0;

   function automatic void model_out(output logic e_led, output logic e_tick, output logic e_busy);
      int h;
      int p;
      e_led  = 1'b0;
      e_tick = 1'b0;
      e_busy = 1'b0;
      case (m_mode)
         1: e_led = 1'b1;
         2: begin
            e_led  = ((m_t / m_hp) % 2) == 0;
            e_tick = (m_t > 0) && ((m_t % m_hp) == 0);
         end
         3: begin
            p      = 2 * m_b + m_g;
            h      = (m_t / m_hp) % p;
            e_led  = ((h % 2) == 0) && (h < 2 * m_b - 1);
            e_busy = (m_g == 0) || (h <= 2 * m_b - 2);
            e_tick = (m_t > 0) && ((m_t % m_hp) == 0);
         end
         default: e_led = 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic el, et, eb;
      model_out(el, et, eb);
      chk("model led_req", led_req, el);
      chk("model tick", tick, et);
      chk("model busy", busy, eb);
      chk("model cfg_ready", cfg_if.cfg_ready, ~eb);
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check at the falling edge.
   task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [7:0] hp,
                       input logic [3:0] b, input logic [3:0] g);
      logic el, et, eb;
      rst                    = r;
      cfg_if.cfg_valid       = v;
      cfg_if.cfg_mode        = m;
      cfg_if.cfg_half_period = hp;
      cfg_if.cfg_burst_count = b;
      cfg_if.cfg_gap_halves  = g;
      model_out(el, et, eb);
      @(posedge clk);
      if (r) begin
         m_mode = 0;
         m_t    = 0;
      end else if (v && !eb) begin
         m_mode = int'(m);
         m_hp   = (hp == 8'd0) ? 1 : int'(hp);
         m_b    = (b == 4'd0) ? 1 : int'(b);
         m_g    = int'(g);
         m_t    = 0;
      end else begin
         m_t++;
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 4'd0);
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [1:0] m;
      logic [7:0] hp;
      logic [3:0] b;
      logic [3:0] g;
      logic       led;
      logic       tk;
      logic       bs;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [1:0] m, input logic [7:0] hp,
                      input logic [3:0] b, input logic [3:0] g,
                      input logic led, input logic tk, input logic bs, input logic rdy);
      vec_t x;
      x.r = r; x.v = v; x.m = m; x.hp = hp; x.b = b; x.g = g;
      x.led = led; x.tk = tk; x.bs = bs; x.rdy = rdy;
      vecs.push_back(x);
   endtask

   initial begin
      logic [19:0] burst_pat;
      logic        rr, acc, pend, el, et, eb;
      logic [1:0]  pm;
      logic [7:0]  php;
      logic [3:0]  pb, pg;
      int          t, waited;

      // Reset, then BLINK hp=4, hp=0 clamp, OFF, and a gap-less single-pulse burst left only by reset.
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 1, 2, 4, 0, 0,   1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
      add(0, 1, 2, 0, 0, 0,   1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0,   1, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
      add(0, 1, 0, 9, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      add(0, 1, 3, 1, 1, 0,   1, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
      add(0, 1, 1, 5, 0, 0,   1, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);

      step(1'b1, 1'b0, 2'd0, 8'd0, 4'd0, 4'd0);
      for (int i = 0; i < 20; i++) idle();

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].v, vecs[i].m, vecs[i].hp, vecs[i].b, vecs[i].g);
         chk($sformatf("vec%0d led_req", i), led_req, vecs[i].led);
         chk($sformatf("vec%0d tick", i), tick, vecs[i].tk);
         chk($sformatf("vec%0d busy", i), busy, vecs[i].bs);
         chk($sformatf("vec%0d cfg_ready", i), cfg_if.cfg_ready, vecs[i].rdy);
      end

      // BURST hp=2 x3 gap=4: 1100 1100 11 then ten low cycles, period 20.
      burst_pat = 20'b00000000001100110011;
      for (t = 0; t < 22; t++) begin
         if (t == 0) step(1'b0, 1'b1, 2'd3, 8'd2, 4'd3, 4'd4);
         else idle();
         chk($sformatf("burst t%0d led_req", t), led_req, burst_pat[t % 20]);
         chk($sformatf("burst t%0d tick", t), tick, (t > 0) && (t % 2 == 0));
         chk($sformatf("burst t%0d busy", t), busy, (t % 20) < 10);
      end

      // Hold an ON offer through the pulse phase; it must wait for the gap.
      waited = 0;
      do begin
         step(1'b0, 1'b1, 2'd1, 8'd3, 4'd0, 4'd0);
         waited++;
      end while (cfg_if.cfg_ready !== 1'b1 && waited < 40);
      chk_int("ON offer cycles until ready", waited, 9);
      step(1'b0, 1'b1, 2'd1, 8'd3, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ON hold%0d led_req", i), led_req, 1'b1);
         chk($sformatf("ON hold%0d tick", i), tick, 1'b0);
         idle();
      end

      // Reset beats a same-cycle offer; the offer lands on the following edge.
      step(1'b0, 1'b1, 2'd2, 8'd3, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) idle();
      step(1'b1, 1'b1, 2'd1, 8'd5, 4'd0, 4'd0);
      chk("rst+valid led_req", led_req, 1'b0);
      chk("rst+valid tick", tick, 1'b0);
      chk("rst+valid busy", busy, 1'b0);
      chk("rst+valid cfg_ready", cfg_if.cfg_ready, 1'b1);
      step(1'b0, 1'b1, 2'd1, 8'd5, 4'd0, 4'd0);
      chk("post-rst accept led_req", led_req, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk($sformatf("post-rst ON%0d led_req", i), led_req, 1'b1);
         chk($sformatf("post-rst ON%0d tick", i), tick, 1'b0);
      end

      // Random offers held until accepted, with occasional reset.
      pend = 1'b0;
      pm = 2'd0; php = 8'd0; pb = 4'd0; pg = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 199) == 0);
         if (!pend && $urandom_range(0, 7) == 0) begin
            pend = 1'b1;
            pm   = 2'($urandom_range(0, 3));
            php  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            pb   = 4'($urandom_range(0, 4));
            pg   = 4'($urandom_range(0, 3));
         end
         model_out(el, et, eb);
         acc = pend && !rr && !eb;
         step(rr, pend, pm, php, pb, pg);
         if (acc) pend = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
